exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Multi-cycle decode/execute control FSM, directly downstream of the fetch controller.
//  - Consumes each instruction the fetch controller latches into IR.
//  - Sequences register-file, ALU and memory strobes (ALU, load, store, branch, jump).
//  - Pulses go_fetch to hand control back for the next instruction.
// PARAMETERS
//  WIDTH        32  datapath/instruction width
//  MEM_TIMEOUT  15  max cycles to wait for mem_ready before flagging a bus error
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  start        in   1      leave IDLE, issue first go_fetch
//  ir_valid     in   1      1-cycle pulse from fetch: ir holds a new instruction
//  ir           in   WIDTH  instruction register contents
//  zero_flag    in   1      ALU result == 0 (valid in EXEC)
//  mem_ready    in   1      memory completed current rd/wr
//  go_fetch     out  1      1-cycle pulse: fetch the next instruction
//  rs1_sel      out  5      register-file read port A select (ir[20:16])
//  rs2_sel      out  5      register-file read port B select (ir[15:11])
//  rd_sel       out  5      register-file write select (ir[25:21])
//  rf_wen       out  1      register-file write enable
//  alu_op       out  4      ALU function
//  alu_src_imm  out  1      ALU operand B = imm_ext
//  imm_ext      out  WIDTH  sign-extended ir[15:0]
//  marEn        out  1      load MAR from ALU result
//  mdrEn        out  1      load MDR (from memory on load, from rs2 on store)
//  ldEn / stEn  out  1      load/store path enables
//  rd / wr      out  1      memory read/write strobes
//  pc_load      out  1      load PC with branch/jump target
//  pc_abs       out  1      target = imm_ext (1) or PC+imm_ext (0)
//  halted       out  1      sticky, in HALT
//  error        out  1      sticky, illegal opcode or memory timeout
// BEHAVIOUR
//  Reset
//  - All outputs 0; state IDLE; timeout counter 0.
//  - Reset mid-instruction aborts at once; no strobe survives the reset edge.
//  Decode
//  - opcode = ir[31:26].
//  - Opcodes: 00 ALU-R, 01 ADDI, 10 LD, 11 ST, 20 BEQ, 21 JMP, 3F HALT; all others illegal.
//  - rs1_sel, rs2_sel, rd_sel and imm_ext are registered in DECODE and held until the next DECODE.
//  States
//  - IDLE  -> FETCHW on start (go_fetch=1 that cycle).
//  - FETCHW -> DECODE when ir_valid=1; otherwise wait indefinitely.
//  - DECODE -> EXEC (ALU-R, ADDI, BEQ, LD, ST) | JUMP | HALT | ERR.
//  - EXEC: alu_op valid; alu_src_imm=1 for ADDI/LD/ST.
//    - ALU-R/ADDI -> WB.
//    - LD/ST -> MADDR.
//    - BEQ: pc_load = zero_flag, pc_abs=0, then -> NEXT.
//  - MADDR: marEn=1 for 1 cycle; ST also mdrEn=1, stEn=1. -> MRD (LD) or MWR (ST).
//  - MRD: rd=1, ldEn=1 held until mem_ready. The mem_ready cycle also asserts mdrEn=1. -> WB.
//  - MWR: wr=1, stEn=1 held until mem_ready. -> NEXT.
//  - WB: rf_wen=1 exactly 1 cycle (rd_sel==0 still strobes; r0 masking is the register file's job). -> NEXT.
//  - JUMP: pc_load=1, pc_abs=1 for 1 cycle. -> NEXT.
//  - NEXT: go_fetch=1 for 1 cycle. -> FETCHW.
//  - HALT: halted=1, absorbing until reset. ERR: error=1, absorbing until reset.
//  Memory timeout
//  - Counter clears on entry to MRD/MWR and increments each cycle while mem_ready=0.
//  - Reaching MEM_TIMEOUT with mem_ready still 0: drop rd/wr, go to ERR.
//  - mem_ready in the same cycle the count reaches MEM_TIMEOUT wins (normal completion).
//  Other rules
//  - ir_valid outside FETCHW is ignored. start outside IDLE is ignored.
//  - Latency (DECODE through NEXT): ALU 4, BEQ/JMP 3, LD 5+wait, ST 4+wait cycles.
// STRUCTURE
//  - Shared package cpu_pkg: opcode constants, alu_op encodings, state encodings, field bit ranges.
//  - One sub-module, instr_decoder: combinational opcode -> class/alu_op/illegal and imm sign-extend.
//  - FSM, timeout counter and output registers live in exec_sequencer.
// TESTING
//  - Reset: reset=1 mid-MRD with rd=1 -> all outputs 0 immediately; IDLE after release.
//  - ADDI r3,r1,-4 (ir=0x0461FFFC), ir_valid -> imm_ext=0xFFFFFFFC, alu_src_imm=1, rf_wen 1 cycle, rd_sel=3, then go_fetch.
//  - LD with mem_ready after 3 wait cycles -> marEn, then rd/ldEn high 4 cycles, mdrEn on ready cycle, rf_wen, go_fetch.
//  - ST, mem_ready never asserted -> wr drops after exactly 15 cycles; error=1, no go_fetch.
//  - BEQ with zero_flag=1 vs 0 -> pc_load=1 (pc_abs=0) vs pc_load=0; go_fetch in both cases.
//  - Opcode 0x3E -> error=1 sticky. Opcode 0x3F -> halted=1. Later ir_valid pulses are ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode/sequencing definitions: instruction field positions, opcodes, ALU codes, FSM states.
// Pure definitions; no latency or backpressure of its own.
package cpu_pkg;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RD_HI    = 25;
  localparam int RD_LO    = 21;
  localparam int RS1_HI   = 20;
  localparam int RS1_LO   = 16;
  localparam int RS2_HI   = 15;
  localparam int RS2_LO   = 11;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int FUNCT_HI = 3;
  localparam int FUNCT_LO = 0;

  localparam logic [5:0] OP_ALUR = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_LD   = 6'h10;
  localparam logic [5:0] OP_ST   = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h20;
  localparam logic [5:0] OP_JMP  = 6'h21;
  localparam logic [5:0] OP_HALT = 6'h3F;

  // ALU-R instructions pass their funct field ir[3:0] straight through as alu_op.
  localparam logic [3:0] ALU_NONE = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_SUB  = 4'h6;

  typedef enum logic [2:0] {
    CLS_ALUR, CLS_ADDI, CLS_LD, CLS_ST, CLS_BEQ, CLS_JMP, CLS_HALT, CLS_ILLEGAL
  } instrClass_t;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCHW, S_DECODE, S_EXEC, S_MADDR, S_MRD, S_MWR,
    S_WB, S_JUMP, S_NEXT, S_HALT, S_ERR
  } state_t;

  function automatic logic usesImm(input instrClass_t cls);
    return (cls == CLS_ADDI) || (cls == CLS_LD) || (cls == CLS_ST);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Opcode -> instruction class / ALU function / illegal flag, plus imm sign extension.
// Purely combinational, zero latency; no backpressure.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       opcode,
  input  logic [3:0]       funct,
  input  logic [15:0]      imm16,
  output instrClass_t      instrClass,
  output logic [3:0]       aluOp,
  output logic             illegal,
  output logic [WIDTH-1:0] immExt
);

  assign immExt = {{(WIDTH-16){imm16[15]}}, imm16};

  always_comb begin
    instrClass = CLS_ILLEGAL;
    aluOp      = ALU_NONE;
    illegal    = 1'b0;
    case (opcode)
      OP_ALUR: begin instrClass = CLS_ALUR; aluOp = funct;   end
      OP_ADDI: begin instrClass = CLS_ADDI; aluOp = ALU_ADD; end
      OP_LD:   begin instrClass = CLS_LD;   aluOp = ALU_ADD; end
      OP_ST:   begin instrClass = CLS_ST;   aluOp = ALU_ADD; end
      OP_BEQ:  begin instrClass = CLS_BEQ;  aluOp = ALU_SUB; end
      OP_JMP:  instrClass = CLS_JMP;
      OP_HALT: instrClass = CLS_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle decode/execute sequencer: DECODE..NEXT takes ALU 4, BEQ/JMP 3, LD 5+mem, ST 4+mem cycles.
// Stalls indefinitely for ir_valid; stalls on mem_ready up to MEM_TIMEOUT cycles, then latches error.
module exec_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ir_valid,
  input  logic [WIDTH-1:0] ir,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             go_fetch,
  output logic [4:0]       rs1_sel,
  output logic [4:0]       rs2_sel,
  output logic [4:0]       rd_sel,
  output logic             rf_wen,
  output logic [3:0]       alu_op,
  output logic             alu_src_imm,
  output logic [WIDTH-1:0] imm_ext,
  output logic             marEn,
  output logic             mdrEn,
  output logic             ldEn,
  output logic             stEn,
  output logic             rd,
  output logic             wr,
  output logic             pc_load,
  output logic             pc_abs,
  output logic             halted,
  output logic             error
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state, nextState;
  instrClass_t      decClass, curClass;
  logic [3:0]       decAluOp, curAluOp;
  logic             decIllegal;
  logic [WIDTH-1:0] decImm;
  logic [CNT_W-1:0] memCnt;
  logic             memTimeout;

  instr_decoder #(.WIDTH(WIDTH)) u_decoder (
    .opcode     (ir[OPC_HI:OPC_LO]),
    .funct      (ir[FUNCT_HI:FUNCT_LO]),
    .imm16      (ir[IMM_HI:IMM_LO]),
    .instrClass (decClass),
    .aluOp      (decAluOp),
    .illegal    (decIllegal),
    .immExt     (decImm)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  // Operand fields are captured once per instruction so ir may change after DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_sel  <= '0;
      rs2_sel  <= '0;
      rd_sel   <= '0;
      imm_ext  <= '0;
      curClass <= CLS_ALUR;
      curAluOp <= ALU_NONE;
    end else if (state == S_DECODE) begin
      rs1_sel  <= ir[RS1_HI:RS1_LO];
      rs2_sel  <= ir[RS2_HI:RS2_LO];
      rd_sel   <= ir[RD_HI:RD_LO];
      imm_ext  <= decImm;
      curClass <= decClass;
      curAluOp <= decAluOp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                              memCnt <= '0;
    else if (state == S_MADDR)                              memCnt <= '0;
    else if ((state == S_MRD || state == S_MWR) && !mem_ready) memCnt <= memCnt + CNT_W'(1);
  end

  // A ready arriving on the final allowed cycle still completes normally.
  assign memTimeout = !mem_ready && (memCnt == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:   if (start)    nextState = S_FETCHW;
      S_FETCHW: if (ir_valid) nextState = S_DECODE;
      S_DECODE: begin
        if (decIllegal) nextState = S_ERR;
        else begin
          case (decClass)
            CLS_JMP:  nextState = S_JUMP;
            CLS_HALT: nextState = S_HALT;
            default:  nextState = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        case (curClass)
          CLS_LD, CLS_ST: nextState = S_MADDR;
          CLS_BEQ:        nextState = S_NEXT;
          default:        nextState = S_WB;
        endcase
      end
      S_MADDR:  nextState = (curClass == CLS_LD) ? S_MRD : S_MWR;
      S_MRD: begin
        if (mem_ready)       nextState = S_WB;
        else if (memTimeout) nextState = S_ERR;
      end
      S_MWR: begin
        if (mem_ready)       nextState = S_NEXT;
        else if (memTimeout) nextState = S_ERR;
      end
      S_WB, S_JUMP: nextState = S_NEXT;
      S_NEXT:       nextState = S_FETCHW;
      default:      nextState = state;
    endcase
  end

  always_comb begin
    go_fetch    = 1'b0;
    rf_wen      = 1'b0;
    alu_op      = ALU_NONE;
    alu_src_imm = 1'b0;
    marEn       = 1'b0;
    mdrEn       = 1'b0;
    ldEn        = 1'b0;
    stEn        = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    pc_load     = 1'b0;
    pc_abs      = 1'b0;
    halted      = 1'b0;
    error       = 1'b0;
    case (state)
      S_IDLE: go_fetch = start;
      S_EXEC: begin
        alu_op      = curAluOp;
        alu_src_imm = usesImm(curClass);
        if (curClass == CLS_BEQ) pc_load = zero_flag;
      end
      S_MADDR: begin
        marEn = 1'b1;
        if (curClass == CLS_ST) begin
          mdrEn = 1'b1;
          stEn  = 1'b1;
        end
      end
      S_MRD: begin
        rd    = 1'b1;
        ldEn  = 1'b1;
        mdrEn = mem_ready;
      end
      S_MWR: begin
        wr   = 1'b1;
        stEn = 1'b1;
      end
      S_WB:   rf_wen = 1'b1;
      S_JUMP: begin
        pc_load = 1'b1;
        pc_abs  = 1'b1;
      end
      S_NEXT: go_fetch = 1'b1;
      S_HALT: halted = 1'b1;
      S_ERR:  error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed and random instructions scored against a per-instruction
// summary model (strobe counts, latency, captured fields, sticky flags).
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, ir_valid, zero_flag, mem_ready;
  logic [31:0] ir;
  logic        go_fetch, rf_wen, alu_src_imm, marEn, mdrEn, ldEn, stEn, rd, wr;
  logic        pc_load, pc_abs, halted, error;
  logic [4:0]  rs1_sel, rs2_sel, rd_sel;
  logic [3:0]  alu_op;
  logic [31:0] imm_ext;

  int nAsserts = 0;
  int nFail    = 0;

  typedef struct {
    int          cycles;
    int          rfWen, rdCnt, wrCnt, mar, mdr, ldCnt, stCnt, pcLoad, pcAbs, srcImm;
    logic [3:0]  aluOp;
    logic        err, halt;
    logic [4:0]  rs1, rs2, rdSel;
    logic [31:0] imm;
  } res_t;

  exec_sequencer #(.WIDTH(32), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .ir_valid(ir_valid), .ir(ir),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .go_fetch(go_fetch),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel), .rf_wen(rf_wen),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm_ext(imm_ext),
    .marEn(marEn), .mdrEn(mdrEn), .ldEn(ldEn), .stEn(stEn), .rd(rd), .wr(wr),
    .pc_load(pc_load), .pc_abs(pc_abs), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] outVec();
    return {go_fetch, rs1_sel, rs2_sel, rd_sel, rf_wen, alu_op, alu_src_imm, imm_ext,
            marEn, mdrEn, ldEn, stEn, rd, wr, pc_load, pc_abs, halted, error};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour of one instruction; w = cycles of wait before mem_ready (-1 = never).
  function automatic res_t model(input logic [31:0] instr, input logic zf, input int w);
    res_t e = '{default: 0};
    logic [5:0] opc = instr[31:26];
    logic [15:0] imm16 = instr[15:0];
    bit memOk = (w >= 0) && (w + 1 <= 15);
    int memCycles = memOk ? w + 1 : 15;
    e.rs1   = instr[20:16];
    e.rs2   = instr[15:11];
    e.rdSel = instr[25:21];
    e.imm   = 32'(signed'(imm16));
    case (opc)
      6'h00: begin e.cycles = 4; e.rfWen = 1; e.aluOp = instr[3:0]; end
      6'h01: begin e.cycles = 4; e.rfWen = 1; e.srcImm = 1; e.aluOp = 4'h2; end
      6'h10: begin
        e.srcImm = 1; e.aluOp = 4'h2; e.mar = 1;
        e.rdCnt = memCycles; e.ldCnt = memCycles;
        if (memOk) begin e.cycles = 5 + memCycles; e.mdr = 1; e.rfWen = 1; end
        else e.err = 1'b1;
      end
      6'h11: begin
        e.srcImm = 1; e.aluOp = 4'h2; e.mar = 1; e.mdr = 1;
        e.wrCnt = memCycles; e.stCnt = 1 + memCycles;
        if (memOk) e.cycles = 4 + memCycles;
        else       e.err = 1'b1;
      end
      6'h20: begin e.cycles = 3; e.pcLoad = int'(zf); e.aluOp = 4'h6; end
      6'h21: begin e.cycles = 3; e.pcLoad = 1; e.pcAbs = 1; end
      6'h3F: e.halt = 1'b1;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Entered just after a negedge in FETCHW; returns just after a negedge in FETCHW, HALT or ERR.
  task automatic runInstr(input logic [31:0] instr, input logic zf, input int w, output res_t o);
    int  memCnt = 0;
    bit  done = 1'b0;
    o = '{default: 0};
    ir = instr; ir_valid = 1'b1; zero_flag = zf; mem_ready = 1'b0;
    for (int idx = 0; idx < 80 && !done; idx++) begin
      @(negedge clk);
      if (idx == 0) ir_valid = 1'b0;
      if (rd || wr) begin
        memCnt++;
        mem_ready = (w >= 0) && (memCnt == w + 1);
      end else mem_ready = 1'b0;
      start = 1'($urandom_range(0, 1));
      #1;
      o.rfWen  += int'(rf_wen);  o.rdCnt += int'(rd);   o.wrCnt  += int'(wr);
      o.mar    += int'(marEn);   o.mdr   += int'(mdrEn); o.ldCnt += int'(ldEn);
      o.stCnt  += int'(stEn);    o.pcLoad += int'(pc_load); o.pcAbs += int'(pc_abs);
      o.srcImm += int'(alu_src_imm);
      if (idx == 1) o.aluOp = alu_op;
      if (go_fetch) begin o.cycles = idx + 1; done = 1'b1; end
      if (error || halted) done = 1'b1;
      if (!done && idx >= 1) begin
        ir_valid = 1'($urandom_range(0, 1));
        ir = $urandom;
      end
    end
    o.err = error; o.halt = halted;
    o.rs1 = rs1_sel; o.rs2 = rs2_sel; o.rdSel = rd_sel; o.imm = imm_ext;
    start = 1'b0; ir_valid = 1'b0; mem_ready = 1'b0;
    if (!done) o.cycles = -1;
    if (o.cycles > 0) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic compareRes(input string n, input res_t o, input res_t e);
    check({n, ".cycles"}, 64'(o.cycles), 64'(e.cycles));
    check({n, ".rf_wen"}, 64'(o.rfWen),  64'(e.rfWen));
    check({n, ".rd"},     64'(o.rdCnt),  64'(e.rdCnt));
    check({n, ".wr"},     64'(o.wrCnt),  64'(e.wrCnt));
    check({n, ".marEn"},  64'(o.mar),    64'(e.mar));
    check({n, ".mdrEn"},  64'(o.mdr),    64'(e.mdr));
    check({n, ".ldEn"},   64'(o.ldCnt),  64'(e.ldCnt));
    check({n, ".stEn"},   64'(o.stCnt),  64'(e.stCnt));
    check({n, ".pc_load"}, 64'(o.pcLoad), 64'(e.pcLoad));
    check({n, ".pc_abs"}, 64'(o.pcAbs),  64'(e.pcAbs));
    check({n, ".src_imm"}, 64'(o.srcImm), 64'(e.srcImm));
    check({n, ".alu_op"}, 64'(o.aluOp),  64'(e.aluOp));
    check({n, ".error"},  64'(o.err),    64'(e.err));
    check({n, ".halted"}, 64'(o.halt),   64'(e.halt));
    check({n, ".fields"}, {23'd0, o.rs1, o.rs2, o.rdSel, o.imm}, {23'd0, e.rs1, e.rs2, e.rdSel, e.imm});
  endtask

  task automatic restart();
    reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  // Absorbing states must ignore further ir_valid/start and keep their flag.
  task automatic stickyCheck(input string n, input logic expHalt, input logic expErr);
    for (int k = 0; k < 4; k++) begin
      ir = 32'h0461FFFC; ir_valid = 1'b1; start = 1'b1;
      @(negedge clk);
      #1;
      check($sformatf("%s.sticky%0d", n, k),
            {59'd0, go_fetch, rf_wen, wr, halted, error}, {59'd0, 1'b0, 1'b0, 1'b0, expHalt, expErr});
    end
    ir_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    res_t o;
    logic [5:0] opcs [6] = '{6'h00, 6'h01, 6'h10, 6'h11, 6'h20, 6'h21};
    logic [31:0] instr;
    reset = 1'b1; start = 1'b0; ir_valid = 1'b0; ir = '0; zero_flag = 1'b0; mem_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1 check("reset_outputs", outVec(), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    #1 check("idle_no_start", 64'(go_fetch), 64'd0);
    start = 1'b1;
    #1 check("idle_start_go_fetch", 64'(go_fetch), 64'd1);
    @(negedge clk);
    start = 1'b0;
    #1 check("fetchw_quiet", 64'(go_fetch), 64'd0);

    runInstr(32'h0461FFFC, 1'b0, 0, o);
    compareRes("addi", o, model(32'h0461FFFC, 1'b0, 0));
    check("addi.imm_const", 64'(o.imm), 64'hFFFF_FFFC);
    check("addi.rd_sel_const", 64'(o.rdSel), 64'd3);

    runInstr(32'h40A20010, 1'b0, 3, o);
    compareRes("ld_w3", o, model(32'h40A20010, 1'b0, 3));
    check("ld_w3.rd_cycles_const", 64'(o.rdCnt), 64'd4);

    runInstr(32'h80011004, 1'b1, 0, o);
    compareRes("beq_taken", o, model(32'h80011004, 1'b1, 0));
    runInstr(32'h80011004, 1'b0, 0, o);
    compareRes("beq_not_taken", o, model(32'h80011004, 1'b0, 0));
    runInstr(32'h84000100, 1'b0, 0, o);
    compareRes("jmp", o, model(32'h84000100, 1'b0, 0));
    runInstr(32'h44221008, 1'b0, 2, o);
    compareRes("st_w2", o, model(32'h44221008, 1'b0, 2));
    runInstr(32'h40A28000, 1'b0, 14, o);
    compareRes("ld_ready_at_limit", o, model(32'h40A28000, 1'b0, 14));

    for (int i = 0; i < 30; i++) begin
      logic zf;
      int   w;
      instr = {opcs[$urandom_range(0, 5)], 26'($urandom)};
      zf    = 1'($urandom_range(0, 1));
      w     = $urandom_range(0, 5);
      runInstr(instr, zf, w, o);
      compareRes($sformatf("rnd%0d", i), o, model(instr, zf, w));
    end

    runInstr(32'h44221008, 1'b0, -1, o);
    compareRes("st_timeout", o, model(32'h44221008, 1'b0, -1));
    check("st_timeout.wr_const", 64'(o.wrCnt), 64'd15);
    stickyCheck("st_timeout", 1'b0, 1'b1);

    restart();
    runInstr(32'h40A20010, 1'b0, -1, o);
    compareRes("ld_timeout", o, model(32'h40A20010, 1'b0, -1));

    restart();
    runInstr(32'hF8000000, 1'b0, 0, o);
    compareRes("illegal_3e", o, model(32'hF8000000, 1'b0, 0));
    stickyCheck("illegal_3e", 1'b0, 1'b1);

    restart();
    runInstr(32'hFC000000, 1'b0, 0, o);
    compareRes("halt", o, model(32'hFC000000, 1'b0, 0));
    stickyCheck("halt", 1'b1, 1'b0);

    // Reset arriving mid-cycle while a load is waiting on memory.
    restart();
    ir = 32'h40A20010; ir_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    ir_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 check("mrd_rd_high", {62'd0, rd, ldEn}, 64'd3);
    #2 reset = 1'b1;
    #1 check("reset_mid_mrd", outVec(), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("post_reset_idle", outVec(), 64'd0);
    start = 1'b1;
    #1 check("post_reset_start", 64'(go_fetch), 64'd1);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
